// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes plus field extract/pack
// and special-value generators. Helpers work on a 64-bit container and
// take the exponent/fraction widths as arguments, so any format up to
// 64 bits can use them.
package fp_pkg;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    localparam int FP_MAX_W = 64;
    typedef logic [FP_MAX_W-1:0] fp_word_t;

    function automatic fp_word_t fp_mask(input int w);
        return (fp_word_t'(1) << w) - fp_word_t'(1);
    endfunction

    function automatic logic fp_get_sign(input fp_word_t x, input int exp_w, input int man_w);
        fp_word_t t;
        t = x >> (exp_w + man_w);
        return t[0];
    endfunction

    function automatic fp_word_t fp_get_exp(input fp_word_t x, input int exp_w, input int man_w);
        return (x >> man_w) & fp_mask(exp_w);
    endfunction

    function automatic fp_word_t fp_get_frac(input fp_word_t x, input int man_w);
        return x & fp_mask(man_w);
    endfunction

    function automatic fp_word_t fp_pack(input logic s, input fp_word_t e, input fp_word_t f,
                                         input int exp_w, input int man_w);
        return (fp_word_t'(s) << (exp_w + man_w)) |
               ((e & fp_mask(exp_w)) << man_w) |
               (f & fp_mask(man_w));
    endfunction

    // A zero exponent covers both zero and subnormal: subnormals are
    // flushed, so both classify as ZERO.
    function automatic fp_class_e fp_classify(input fp_word_t e, input fp_word_t f, input int exp_w);
        if (e == '0)
            return ZERO;
        else if (e == fp_mask(exp_w))
            return (f == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

    function automatic fp_word_t fp_inf(input logic s, input int exp_w, input int man_w);
        return fp_pack(s, fp_mask(exp_w), '0, exp_w, man_w);
    endfunction

    function automatic fp_word_t fp_qnan(input int exp_w, input int man_w);
        return fp_pack(1'b0, fp_mask(exp_w), fp_word_t'(1) << (man_w - 1), exp_w, man_w);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zero bits above the most significant
// one; equals DATA_W for an all-zero input.
module fp_lzc #(
    parameter int DATA_W = 28
) (
    input  logic [DATA_W-1:0]           din,
    output logic [$clog2(DATA_W+1)-1:0] cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic found;

    // Scan from the MSB down, counting zeros until the first one.
    always_comb begin
        cnt   = '0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (din[i])
                    found = 1'b1;
                else
                    cnt = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready flow
// control, a pass-through tag and overflow/invalid/inexact flags.
// S1 classify/swap/align, S2 add/subtract, S3 normalise/round/pack.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     flag_ovf,
    output logic                     flag_inv,
    output logic                     flag_inx
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 4;           // hidden + fraction + G/R/S
    localparam int SW     = MW + 1;              // plus carry
    localparam int LZ_W   = $clog2(SW + 1);
    localparam int EXP_SW = (EXP_W + 2 > LZ_W + 2) ? EXP_W + 2 : LZ_W + 2;
    localparam logic signed [EXP_SW-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_SW-1:0] EXP_TOP  = EXP_SW'({EXP_W{1'b1}});

    // Whole pipeline moves together; a stalled output freezes every stage.
    logic advance;
    logic out_valid_q;
    assign advance  = out_ready || !out_valid_q;
    assign in_ready = advance;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [MW-1:0]    ma, mb, m_small;
    fp_class_e        ca, cb;
    int               sh;

    logic             vld_p1_d, vld_p1_q;
    logic             sign_p1_d, sign_p1_q;
    logic             eff_sub_p1_d, eff_sub_p1_q;
    logic             zsign_p1_d, zsign_p1_q;
    logic             spec_p1_d, spec_p1_q;
    logic             spec_inv_p1_d, spec_inv_p1_q;
    logic [W-1:0]     spec_res_p1_d, spec_res_p1_q;
    logic [EXP_W-1:0] exp_p1_d, exp_p1_q;
    logic [MW-1:0]    mbig_p1_d, mbig_p1_q;
    logic [MW-1:0]    msml_p1_d, msml_p1_q;
    logic [TAG_W-1:0] tag_p1_d, tag_p1_q;

    // Classify operands, pick the larger magnitude and align the smaller one.
    always_comb begin
        sa = fp_get_sign(fp_word_t'(a), EXP_W, MAN_W);
        sb = fp_get_sign(fp_word_t'(b), EXP_W, MAN_W) ^ sub;
        ea = EXP_W'(fp_get_exp(fp_word_t'(a), EXP_W, MAN_W));
        eb = EXP_W'(fp_get_exp(fp_word_t'(b), EXP_W, MAN_W));
        fa = MAN_W'(fp_get_frac(fp_word_t'(a), MAN_W));
        fb = MAN_W'(fp_get_frac(fp_word_t'(b), MAN_W));
        ca = fp_classify(fp_word_t'(ea), fp_word_t'(fa), EXP_W);
        cb = fp_classify(fp_word_t'(eb), fp_word_t'(fb), EXP_W);
        // Subnormals flush to zero: no hidden bit, no fraction.
        ma = (ca == NORM) ? {1'b1, fa, 3'b000} : '0;
        mb = (cb == NORM) ? {1'b1, fb, 3'b000} : '0;

        if ({ea, ma} >= {eb, mb}) begin
            sign_p1_d = sa;
            exp_p1_d  = ea;
            mbig_p1_d = ma;
            m_small   = mb;
            diff      = ea - eb;
        end else begin
            sign_p1_d = sb;
            exp_p1_d  = eb;
            mbig_p1_d = mb;
            m_small   = ma;
            diff      = eb - ea;
        end

        // Beyond MAN_W+3 the hidden bit lands in the sticky position anyway.
        sh = (int'(diff) > MAN_W + 3) ? MAN_W + 3 : int'(diff);
        msml_p1_d = (m_small >> sh) |
                    MW'(|(m_small & ((MW'(1) << sh) - MW'(1))));

        eff_sub_p1_d = sa ^ sb;
        zsign_p1_d   = (ca == ZERO) && (cb == ZERO) && sa && sb;

        spec_p1_d     = 1'b0;
        spec_inv_p1_d = 1'b0;
        spec_res_p1_d = '0;
        if (ca == NAN || cb == NAN || (ca == INF && cb == INF && sa != sb)) begin
            spec_p1_d     = 1'b1;
            spec_inv_p1_d = 1'b1;
            spec_res_p1_d = W'(fp_qnan(EXP_W, MAN_W));
        end else if (ca == INF) begin
            spec_p1_d     = 1'b1;
            spec_res_p1_d = W'(fp_inf(sa, EXP_W, MAN_W));
        end else if (cb == INF) begin
            spec_p1_d     = 1'b1;
            spec_res_p1_d = W'(fp_inf(sb, EXP_W, MAN_W));
        end

        vld_p1_d = in_valid;
        tag_p1_d = in_tag;
    end

    // ---------------- S2: add / subtract aligned mantissas ----------------
    logic             vld_p2_d, vld_p2_q;
    logic [SW-1:0]    sum_p2_d, sum_p2_q;
    logic             sign_p2_d, sign_p2_q;
    logic             zsign_p2_d, zsign_p2_q;
    logic             spec_p2_d, spec_p2_q;
    logic             spec_inv_p2_d, spec_inv_p2_q;
    logic [W-1:0]     spec_res_p2_d, spec_res_p2_q;
    logic [EXP_W-1:0] exp_p2_d, exp_p2_q;
    logic [TAG_W-1:0] tag_p2_d, tag_p2_q;

    // Larger magnitude is always the minuend, so the difference never goes negative.
    always_comb begin
        sum_p2_d      = eff_sub_p1_q ? ({1'b0, mbig_p1_q} - {1'b0, msml_p1_q})
                                     : ({1'b0, mbig_p1_q} + {1'b0, msml_p1_q});
        vld_p2_d      = vld_p1_q;
        sign_p2_d     = sign_p1_q;
        zsign_p2_d    = zsign_p1_q;
        spec_p2_d     = spec_p1_q;
        spec_inv_p2_d = spec_inv_p1_q;
        spec_res_p2_d = spec_res_p1_q;
        exp_p2_d      = exp_p1_q;
        tag_p2_d      = tag_p1_q;
    end

    // ---------------- S3: normalise, round, pack, override ----------------
    logic [LZ_W-1:0]          lz;
    logic [SW-1:0]            norm;
    logic                     rnd, stk, round_up, rcarry;
    logic [MAN_W-1:0]         frac_f;
    logic signed [EXP_SW-1:0] exp_n, exp_f;

    logic                     out_valid_d;
    logic [W-1:0]             result_d, result_q;
    logic [TAG_W-1:0]         out_tag_d, out_tag_q;
    logic                     flag_ovf_d, flag_ovf_q;
    logic                     flag_inv_d, flag_inv_q;
    logic                     flag_inx_d, flag_inx_q;

    fp_lzc #(.DATA_W(SW)) u_lzc (
        .din (sum_p2_q),
        .cnt (lz)
    );

    // Shift the leading one to the carry position, round to nearest even, then apply overrides.
    always_comb begin
        norm              = sum_p2_q << lz;
        rnd               = norm[3];
        stk               = |norm[2:0];
        round_up          = rnd & (stk | norm[4]);
        {rcarry, frac_f}  = {1'b0, norm[SW-2:4]} + (MAN_W + 1)'(round_up);
        exp_n             = EXP_SW'(exp_p2_q) + EXP_SW'(1) - EXP_SW'(lz);
        exp_f             = exp_n + EXP_SW'(rcarry);

        result_d   = W'(fp_pack(sign_p2_q, fp_word_t'(exp_f[EXP_W-1:0]),
                                fp_word_t'(frac_f), EXP_W, MAN_W));
        flag_ovf_d = 1'b0;
        flag_inv_d = 1'b0;
        flag_inx_d = rnd | stk;

        if (spec_p2_q) begin
            result_d   = spec_res_p2_q;
            flag_inv_d = spec_inv_p2_q;
            flag_inx_d = 1'b0;
        end else if (!norm[SW-1]) begin
            // Exact zero: only (-0)+(-0) keeps the negative sign.
            result_d   = {zsign_p2_q, {(W-1){1'b0}}};
            flag_inx_d = 1'b0;
        end else if (exp_f >= EXP_TOP) begin
            result_d   = W'(fp_inf(sign_p2_q, EXP_W, MAN_W));
            flag_ovf_d = 1'b1;
            flag_inx_d = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            result_d   = '0;
            flag_inx_d = 1'b0;
        end

        out_valid_d = vld_p2_q;
        out_tag_d   = tag_p2_q;
    end

    // Valid bits and visible outputs: cleared by reset, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
            flag_ovf_q  <= 1'b0;
            flag_inv_q  <= 1'b0;
            flag_inx_q  <= 1'b0;
        end else if (advance) begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
            flag_ovf_q  <= flag_ovf_d;
            flag_inv_q  <= flag_inv_d;
            flag_inx_q  <= flag_inx_d;
        end
    end

    // Internal datapath registers: meaningful only under their valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p1_q     <= sign_p1_d;
            eff_sub_p1_q  <= eff_sub_p1_d;
            zsign_p1_q    <= zsign_p1_d;
            spec_p1_q     <= spec_p1_d;
            spec_inv_p1_q <= spec_inv_p1_d;
            spec_res_p1_q <= spec_res_p1_d;
            exp_p1_q      <= exp_p1_d;
            mbig_p1_q     <= mbig_p1_d;
            msml_p1_q     <= msml_p1_d;
            tag_p1_q      <= tag_p1_d;
            sum_p2_q      <= sum_p2_d;
            sign_p2_q     <= sign_p2_d;
            zsign_p2_q    <= zsign_p2_d;
            spec_p2_q     <= spec_p2_d;
            spec_inv_p2_q <= spec_inv_p2_d;
            spec_res_p2_q <= spec_res_p2_d;
            exp_p2_q      <= exp_p2_d;
            tag_p2_q      <= tag_p2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign flag_ovf  = flag_ovf_q;
    assign flag_inv  = flag_inv_q;
    assign flag_inx  = flag_inx_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (binary32 configuration).
module tb_fp_addsub_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 2;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             sub = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic             flag_ovf, flag_inv, flag_inx;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .flag_ovf  (flag_ovf),
        .flag_inv  (flag_inv),
        .flag_inx  (flag_inx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {ovf, inv, inx}
        logic [1:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Directed vectors: a, b, sub, expected result, expected {ovf,inv,inx}.
    localparam int ND = 14;
    localparam logic [31:0] TA [ND] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                                        32'h7F7FFFFF, 32'h3F800000, 32'h00400000, 32'h3F800001,
                                        32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h40400000,
                                        32'h3FC00000, 32'h00800001};
    localparam logic [31:0] TB [ND] = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                                        32'h7F7FFFFF, 32'h33800000, 32'h00000000, 32'h33800000,
                                        32'h3F800000, 32'hFF800000, 32'h33000000, 32'h3F800000,
                                        32'h3F800000, 32'h00800000};
    localparam logic        TS [ND] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [31:0] TR [ND] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h7FC00000,
                                        32'h7F800000, 32'h3F800000, 32'h00000000, 32'h3F800002,
                                        32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                                        32'h3F000000, 32'h00000000};
    localparam logic [2:0]  TF [ND] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b101, 3'b001, 3'b000,
                                        3'b001, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};

    // Stream vectors: 1+1, 2+2, 3-1, 1.5+0.25, -1+0.5, 5-7.
    localparam int NS = 6;
    localparam logic [31:0] SA [NS] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                        32'h3FC00000, 32'hBF800000, 32'h40A00000};
    localparam logic [31:0] SB [NS] = '{32'h3F800000, 32'h40000000, 32'h3F800000,
                                        32'h3E800000, 32'h3F000000, 32'h40E00000};
    localparam logic        SS [NS] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] SR [NS] = '{32'h40000000, 32'h40800000, 32'h40000000,
                                        32'h3FE00000, 32'hBF000000, 32'hC0000000};

    // Drive one operation (called just after a rising edge); push its expectation on acceptance.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic [1:0] tg, input logic [31:0] er, input logic [2:0] ef,
                        input bit lat);
        exp_t e;
        int   w;
        w        = 0;
        a        = ta;
        b        = tb;
        sub      = ts;
        in_tag   = tg;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.res = er;
                e.flg = ef;
                e.tag = tg;
                e.acc = cyc;
                e.lat = lat;
                sb_q.push_back(e);
                break;
            end
            w++;
            if (w > 50) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every transfer and watches stall behaviour.
    exp_t        mon_e;
    logic        hold_v = 1'b0;
    logic [31:0] hold_res;
    logic [1:0]  hold_tag;
    logic [2:0]  hold_flg;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_vld", 32'(out_valid), 32'd1);
                check("hold_res", result, hold_res);
                check("hold_tag", 32'(out_tag), 32'(hold_tag));
                check("hold_flg", 32'({flag_ovf, flag_inv, flag_inx}), 32'(hold_flg));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                hold_v   = 1'b1;
                hold_res = result;
                hold_tag = out_tag;
                hold_flg = {flag_ovf, flag_inv, flag_inx};
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("result", result, mon_e.res);
                    check("tag", 32'(out_tag), 32'(mon_e.tag));
                    check("flags", 32'({flag_ovf, flag_inv, flag_inx}), 32'(mon_e.flg));
                    if (mon_e.lat)
                        check("latency", 32'(cyc - mon_e.acc), 32'd3);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_flags", 32'({flag_ovf, flag_inv, flag_inx}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases back-to-back with no back-pressure.
        for (int i = 0; i < ND; i++)
            send(TA[i], TB[i], TS[i], 2'(i % 4), TR[i], TF[i], 1'b1);
        drain("drain_directed");

        // Stream of six with a four-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < NS; i++)
                    send(SA[i], SB[i], SS[i], 2'(i % 4), SR[i], 3'b000, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stream");

        // Reset with two operations in flight: both must vanish.
        send(32'h3F800000, 32'h3F800000, 1'b0, 2'd1, 32'h40000000, 3'b000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 2'd2, 32'h40800000, 3'b000, 1'b0);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'h3F800000, 32'h40000000, 1'b0, 2'd3, 32'h40400000, 3'b000, 1'b1);
        drain("drain_post_rst");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
